serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single `full_adder` cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- The carry is fed back through a flip-flop.
- Operands are captured on a start handshake; a registered result is presented with a one-cycle `done` pulse.
- It sits beside the combinational adder as the area-minimal alternative for multi-bit additions.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 2..32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when the block is not busy.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `cin`  in  1  carry-in; sampled with `start`.
- `busy`  out  1  high while an addition is in progress (RUN state).
- `done`  out  1  one-cycle pulse; `sum`/`cout` valid from this cycle.
- `sum`  out  WIDTH  registered result; holds until the next completion.
- `cout`  out  1  registered carry-out of the MSB.
- `ovf`  out  1  signed overflow; present only with `SERIAL_ADD_OVF_EN`.

## Operation
- Exactly one `full_adder` instance.
  - Its `a`/`b` inputs are the LSBs of the operand shift registers.
  - Its `cin` input is the carry flip-flop.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with `start`=1:
  - Load `a` and `b` into the shift registers.
  - Load `cin` into the carry flip-flop.
  - Clear the bit counter (width $clog2(WIDTH)).
  - Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, every cycle:
  - Shift both operands right by one.
  - Shift the adder `s` into the MSB of the internal sum shift register.
  - Carry flip-flop <= adder `cout`.
  - Increment the counter.
- RUN exit: when the counter equals WIDTH-1, after that cycle's update, go to DONE and copy into the output registers:
  - the final sum shift register value into `sum`;
  - the final carry into `cout`.
- DONE: `done`=1 for this cycle only.
  - Next state is RUN if `start`=1, giving back-to-back operation; otherwise IDLE.
- `start` in RUN is ignored; it is not queued.
- Operand inputs are don't-care except in the cycle `start` is accepted.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1); unsigned, no saturation.
- The `sum`/`cout` output registers change only on RUN->DONE.
  - The internal shift register is never visible on the ports.
- Reset, including mid-operation:
  - state IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0;
  - counter, carry and shift registers cleared;
  - the aborted operation produces no `done`.

## Timing
- Edge E0: `start` sampled high in IDLE or DONE.
- `busy` is high for exactly WIDTH cycles, starting the cycle after E0.
- `done` is high in the cycle after the last RUN cycle. With WIDTH=8 that is WIDTH+1 = 9 cycles after E0.
- Throughput with `start` held high: one result every WIDTH+1 cycles.
- `busy` and `done` are never high simultaneously.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - Adds output port `ovf`.
  - On the last RUN cycle the carry into the MSB, i.e. the carry flip-flop value, is XORed with the MSB carry-out.
  - The result is registered into `ovf` alongside `sum`/`cout`, giving two's-complement overflow.
  - Reset value 0.
- `SERIAL_ADD_OVF_EN` undefined: no `ovf` port and no extra logic; all other behaviour identical.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0 -> `busy` high 8 cycles, then `done` pulse with `sum`=0x96, `cout`=0, `ovf`=1 (if enabled).
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1, `ovf`=0; then `a`=0x00, `b`=0x00, `cin`=1 -> `sum`=0x01, `cout`=0.
- Pulse `start` again 3 cycles into RUN with different operands -> ignored; result is still from the first operands; `done` exactly once.
- `start` held high continuously with 0x10+0x20, then 0x7F+0x01 presented in the DONE cycle -> results 0x30, then 0x80 (`ovf`=1); `done` pulses 9 cycles apart.
- Assert `rst_n`=0 asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; no `done`; a following `start` computes a correct new sum.
- Random 1000 operand/`cin` triples at WIDTH=8 and WIDTH=13 -> {`cout`,`sum`} matches the `a`+`b`+`cin` reference model every time.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Handshake/result bundle for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell reused over WIDTH cycles, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Output registers take the fully shifted value on the final bit.
          state_d = DONE;
          sum_d   = sum_sh_d;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=13 against an arithmetic model.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_ctrl_if #(.WIDTH(13)) if13 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition and signed range check.
  function automatic void ref_add(input int w, input longint a, input longint b, input longint c,
                                  output longint res, output bit ovf);
    longint one, sa, sb, ss;
    one = 1;
    res = (a + b + c) % (one << (w + 1));
    sa  = (a >= (one << (w - 1))) ? a - (one << w) : a;
    sb  = (b >= (one << (w - 1))) ? b - (one << w) : b;
    ss  = sa + sb + c;
    ovf = (ss > (one << (w - 1)) - 1) || (ss < -(one << (w - 1)));
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit mid, input string tag);
    longint er; bit eo; int n, nb, nd, extra; bit ovl;
    ref_add(8, a, b, c, er, eo);
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
    n = 0; nb = 0; nd = 0; ovl = 1'b0;
    while (nd == 0 && n < 40) begin
      @(negedge clk); n++;
      if (if8.busy) nb++;
      if (if8.busy && if8.done) ovl = 1'b1;
      if (if8.done) nd = 1;
      if (mid && n == 3) begin
        if8.start = 1'b1; if8.a = ~a; if8.b = a ^ 8'h5A; if8.cin = ~c;
      end
      if (mid && n == 4) if8.start = 1'b0;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_busy_done_overlap"}, ovl, 0);
    chk({tag, "_result"}, {if8.cout, if8.sum}, er);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, if8.ovf, eo);
`endif
    if (mid) begin
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (if8.done) extra++;
      end
      chk({tag, "_extra_done"}, extra, 0);
    end
  endtask

  task automatic run13(input logic [12:0] a, input logic [12:0] b, input logic c);
    longint er; bit eo; int n, nb; bit got;
    ref_add(13, a, b, c, er, eo);
    @(posedge clk); #1;
    if13.start = 1'b1; if13.a = a; if13.b = b; if13.cin = c;
    @(posedge clk); #1;
    if13.start = 1'b0; if13.a = 13'($urandom); if13.b = 13'($urandom);
    n = 0; nb = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk); n++;
      if (if13.busy) nb++;
      if (if13.done) got = 1'b1;
    end
    chk("w13_lat", n, 14);
    chk("w13_busy_cycles", nb, 13);
    chk("w13_result", {if13.cout, if13.sum}, er);
`ifdef SERIAL_ADD_OVF_EN
    chk("w13_ovf", if13.ovf, eo);
`endif
  endtask

  initial begin
    int n, first, second, nd;
    rst_n = 1'b0;
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;
    if13.start = 1'b0; if13.a = '0; if13.b = '0; if13.cin = 1'b0;
    #12;
    chk("reset_busy", if8.busy, 0);
    chk("reset_done", if8.done, 0);
    chk("reset_sum",  if8.sum, 0);
    chk("reset_cout", if8.cout, 0);
    @(negedge clk); rst_n = 1'b1;

    run8(8'h5A, 8'h3C, 1'b0, 1'b0, "5a_3c");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "ff_01");
    run8(8'h00, 8'h00, 1'b1, 1'b0, "00_00_c1");
    run8(8'h21, 8'h43, 1'b0, 1'b1, "ignored_start");

    // Back-to-back with start held high; second operands applied in the DONE cycle.
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
    n = 0; first = 0; second = 0;
    while (second == 0 && n < 60) begin
      @(negedge clk); n++;
      if (if8.done) begin
        if (first == 0) begin
          first = n;
          chk("b2b_first", {if8.cout, if8.sum}, 9'h030);
          if8.a = 8'h7F; if8.b = 8'h01;
        end else begin
          second = n;
          if8.start = 1'b0;
          chk("b2b_second", {if8.cout, if8.sum}, 9'h080);
`ifdef SERIAL_ADD_OVF_EN
          chk("b2b_second_ovf", if8.ovf, 1);
`endif
        end
      end
    end
    if8.start = 1'b0;
    chk("b2b_spacing", second - first, 9);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", if8.busy, 0);
    chk("arst_done", if8.done, 0);
    chk("arst_sum",  if8.sum, 0);
    chk("arst_cout", if8.cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("arst_ovf", if8.ovf, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (if8.done) nd++;
    end
    chk("arst_no_done", nd, 0);
    run8(8'hC3, 8'h4E, 1'b1, 1'b0, "after_arst");

    for (int i = 0; i < 1000; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "w8_rand");
    for (int i = 0; i < 1000; i++)
      run13(13'($urandom), 13'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
